// File: rtl/alu_share_arb_if.sv
// rtl/alu_share_arb_if.sv - request/response bundle between two clients and the shared ALU arbiter
interface alu_share_arb_if #(parameter int W = 32);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;
    logic [2:0]   req0_op;
    logic         resp0_valid;
    logic         resp0_ready;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;
    logic [2:0]   req1_op;
    logic         resp1_valid;
    logic         resp1_ready;
    logic [W:0]   resp_result;
    logic         busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin, req0_op, resp0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin, req1_op, resp1_ready,
        output req0_ready, resp0_valid, req1_ready, resp1_valid, resp_result, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin, req0_op, resp0_ready,
        output req1_valid, req1_a, req1_b, req1_cin, req1_op, resp1_ready,
        input  req0_ready, resp0_valid, req1_ready, resp1_valid, resp_result, busy
    );
endinterface

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin arbiter sharing one ripple ALU between two requesters
module nbit_ALU #(parameter int W = 32) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    input  logic [2:0]   alop,
    output logic [W:0]   result
);
    always_comb begin
        logic [W:0]   c;
        logic [W-1:0] bx;
        logic [W-1:0] s;
        bx = (alop == 3'b101) ? ~b : ((alop == 3'b100) ? '0 : b);
        c    = '0;
        s    = '0;
        c[0] = c_in;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ bx[i] ^ c[i];
            c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
        case (alop)
            3'b000:  result = {c[W], s};
            3'b001:  result = {1'b0, a & b};
            3'b010:  result = {1'b0, a | b};
            3'b011:  result = {1'b0, a ^ b};
            3'b100:  result = {c[W], s};
            // subtract reports borrow, the inverse of the adder carry
            3'b101:  result = {~c[W], s};
            3'b110:  result = {1'b0, ~(a | b)};
            default: result = {1'b0, b};
        endcase
    end
endmodule

module alu_share_arb #(parameter int W = 32) (
    input  logic            clk,
    input  logic            reset,
    alu_share_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state;
    logic         owner;
    logic         last_grant;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic [2:0]   op_code;
    logic [W:0]   alu_y;
    logic [W:0]   result_q;
    logic         resp0_q;
    logic         resp1_q;
    logic         busy_q;
    logic         any_req;
    logic         grant1;
    logic         owner_ready;

    nbit_ALU #(.W(W)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .c_in   (op_cin),
        .alop   (op_code),
        .result (alu_y)
    );

    // requester 1 wins only when alone or when requester 0 had the previous grant
    assign any_req     = bus.req0_valid | bus.req1_valid;
    assign grant1      = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    assign owner_ready = owner ? bus.resp1_ready : bus.resp0_ready;

    assign bus.req0_ready  = ~reset & (state == IDLE) & bus.req0_valid & ~grant1;
    assign bus.req1_ready  = ~reset & (state == IDLE) & grant1;
    assign bus.resp0_valid = resp0_q;
    assign bus.resp1_valid = resp1_q;
    assign bus.resp_result = result_q;
    assign bus.busy        = busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_cin     <= 1'b0;
            op_code    <= '0;
            result_q   <= '0;
            resp0_q    <= 1'b0;
            resp1_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner      <= grant1;
                        last_grant <= grant1;
                        op_a       <= grant1 ? bus.req1_a   : bus.req0_a;
                        op_b       <= grant1 ? bus.req1_b   : bus.req0_b;
                        op_cin     <= grant1 ? bus.req1_cin : bus.req0_cin;
                        op_code    <= grant1 ? bus.req1_op  : bus.req0_op;
                        busy_q     <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= alu_y;
                    resp0_q  <= ~owner;
                    resp1_q  <= owner;
                    state    <= RESP;
                end
                RESP: begin
                    if (owner_ready) begin
                        resp0_q <= 1'b0;
                        resp1_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed and randomized checks of the shared ALU arbiter
module tb_alu_share_arb;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    alu_share_arb_if #(.W(32)) bus ();

    alu_share_arb #(.W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic cin, input logic [2:0] op);
        logic [32:0] t;
        case (op)
            3'b000:  alu_model = {1'b0, a} + {1'b0, b} + {32'b0, cin};
            3'b001:  alu_model = {1'b0, a & b};
            3'b010:  alu_model = {1'b0, a | b};
            3'b011:  alu_model = {1'b0, a ^ b};
            3'b100:  alu_model = {1'b0, a} + {32'b0, cin};
            3'b101: begin
                t = {1'b0, a} + {1'b0, ~b} + {32'b0, cin};
                alu_model = {~t[32], t[31:0]};
            end
            3'b110:  alu_model = {1'b0, ~(a | b)};
            default: alu_model = {1'b0, b};
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_cin = 0; bus.req0_op = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_cin = 0; bus.req1_op = 0;
        bus.resp0_ready = 0; bus.resp1_ready = 0;
    endtask

    task automatic drain;
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.resp0_ready = 1; bus.resp1_ready = 1;
        for (int i = 0; i < 6; i++) tick();
        bus.resp0_ready = 0; bus.resp1_ready = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1;
        tick(); tick();
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
        total_cnt++;
        if ({bus.resp0_valid, bus.resp1_valid} !== 2'b00)
            $display("FAIL reset_resp_valid got %b want 00", {bus.resp0_valid, bus.resp1_valid});
        else pass_cnt++;
        total_cnt++;
        if (bus.resp_result !== 33'h0) $display("FAIL reset_result got %h want 0", bus.resp_result); else pass_cnt++;
        total_cnt++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00)
            $display("FAIL reset_ready got %b want 00", {bus.req0_ready, bus.req1_ready});
        else pass_cnt++;
        reset = 0;
        tick();
    endtask

    task automatic test_basic_sub;
        bus.req0_valid = 1; bus.req0_a = 32'h0000000A; bus.req0_b = 32'h00000003;
        bus.req0_cin = 1; bus.req0_op = 3'b101;
        #1;
        total_cnt++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
            $display("FAIL sub_accept got %b want 10", {bus.req0_ready, bus.req1_ready});
        else pass_cnt++;
        tick();
        bus.req0_valid = 0;
        total_cnt++;
        if ({bus.busy, bus.resp0_valid} !== 2'b10)
            $display("FAIL sub_exec busy/valid got %b want 10", {bus.busy, bus.resp0_valid});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.resp0_valid, bus.resp1_valid} !== 2'b10)
            $display("FAIL sub_resp_valid got %b want 10", {bus.resp0_valid, bus.resp1_valid});
        else pass_cnt++;
        total_cnt++;
        if (bus.resp_result !== 33'h0_00000007)
            $display("FAIL sub_result got %h want 000000007", bus.resp_result);
        else pass_cnt++;
        bus.resp0_ready = 1;
        tick();
        bus.resp0_ready = 0;
        total_cnt++;
        if ({bus.busy, bus.resp0_valid} !== 2'b00)
            $display("FAIL sub_release got %b want 00", {bus.busy, bus.resp0_valid});
        else pass_cnt++;
    endtask

    task automatic test_borrow;
        bus.req1_valid = 1; bus.req1_a = 32'd3; bus.req1_b = 32'd10;
        bus.req1_cin = 1; bus.req1_op = 3'b101;
        #1;
        total_cnt++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b01)
            $display("FAIL borrow_accept got %b want 01", {bus.req0_ready, bus.req1_ready});
        else pass_cnt++;
        tick();
        bus.req1_valid = 0;
        tick();
        total_cnt++;
        if ({bus.resp0_valid, bus.resp1_valid} !== 2'b01)
            $display("FAIL borrow_resp_valid got %b want 01", {bus.resp0_valid, bus.resp1_valid});
        else pass_cnt++;
        total_cnt++;
        if (bus.resp_result !== 33'h1_FFFFFFF9)
            $display("FAIL borrow_result got %h want 1FFFFFFF9", bus.resp_result);
        else pass_cnt++;
        bus.resp1_ready = 1;
        tick();
        bus.resp1_ready = 0;
    endtask

    task automatic test_back_to_back;
        int n = 0;
        logic g[8];
        int   at[8];
        bus.req0_valid = 1; bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_cin = 0; bus.req0_op = 3'b000;
        bus.req1_valid = 1; bus.req1_a = 32'h00FF; bus.req1_b = 32'h0F0F; bus.req1_cin = 0; bus.req1_op = 3'b011;
        bus.resp0_ready = 1; bus.resp1_ready = 1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (bus.req0_ready | bus.req1_ready) begin
                total_cnt++;
                if (bus.busy !== 1'b0) $display("FAIL b2b_grant_while_busy cycle %0d busy %b want 0", cyc, bus.busy);
                else pass_cnt++;
                if (n < 8) begin g[n] = bus.req1_ready; at[n] = cyc; end
                n++;
            end
            if (bus.resp0_valid) begin
                total_cnt++;
                if (bus.resp_result !== 33'd3) $display("FAIL b2b_result0 got %h want 3", bus.resp_result);
                else pass_cnt++;
            end
            if (bus.resp1_valid) begin
                total_cnt++;
                if (bus.resp_result !== 33'h0FF0) $display("FAIL b2b_result1 got %h want ff0", bus.resp_result);
                else pass_cnt++;
            end
            tick();
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        total_cnt++;
        if (n !== 4) $display("FAIL b2b_grant_count got %0d want 4", n); else pass_cnt++;
        for (int i = 0; i < 4 && i < n; i++) begin
            total_cnt++;
            if (g[i] !== logic'(i % 2)) $display("FAIL b2b_order op %0d got %b want %0d", i, g[i], i % 2);
            else pass_cnt++;
            if (i > 0) begin
                total_cnt++;
                if (at[i] - at[i-1] !== 3) $display("FAIL b2b_spacing op %0d got %0d want 3", i, at[i] - at[i-1]);
                else pass_cnt++;
            end
        end
        drain();
    endtask

    task automatic test_backpressure;
        logic [32:0] held;
        bus.req0_valid = 1; bus.req0_a = 32'hF0F0F0F0; bus.req0_b = 32'hFF00FF00; bus.req0_cin = 0; bus.req0_op = 3'b001;
        bus.req1_a = 32'd5; bus.req1_b = 32'd6; bus.req1_cin = 0; bus.req1_op = 3'b000;
        #1;
        total_cnt++;
        if (bus.req0_ready !== 1'b1) $display("FAIL bp_accept got %b want 1", bus.req0_ready); else pass_cnt++;
        tick();
        bus.req0_valid = 0;
        bus.req1_valid = 1;
        #1;
        total_cnt++;
        if (bus.req1_ready !== 1'b0) $display("FAIL bp_exec_ready1 got %b want 0", bus.req1_ready); else pass_cnt++;
        tick();
        held = 33'h0_F000F000;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({bus.resp0_valid, bus.req1_ready, bus.resp_result} !== {2'b10, held})
                $display("FAIL bp_hold cycle %0d got valid=%b ready1=%b result=%h want 1 0 %h",
                         i, bus.resp0_valid, bus.req1_ready, bus.resp_result, held);
            else pass_cnt++;
            tick();
        end
        bus.resp0_ready = 1;
        tick();
        bus.resp0_ready = 0;
        total_cnt++;
        if ({bus.req1_ready, bus.resp0_valid, bus.busy} !== 3'b100)
            $display("FAIL bp_next_grant got %b want 100", {bus.req1_ready, bus.resp0_valid, bus.busy});
        else pass_cnt++;
        tick();
        bus.req1_valid = 0;
        tick();
        total_cnt++;
        if ({bus.resp1_valid, bus.resp_result} !== {1'b1, 33'd11})
            $display("FAIL bp_req1_result got %b %h want 1 00000000b", bus.resp1_valid, bus.resp_result);
        else pass_cnt++;
        bus.resp1_ready = 1;
        tick();
        bus.resp1_ready = 0;
    endtask

    task automatic test_reset_mid;
        bus.req0_valid = 1; bus.req0_a = 32'd100; bus.req0_b = 32'd1; bus.req0_cin = 0; bus.req0_op = 3'b000;
        bus.req1_valid = 1; bus.req1_a = 32'd7; bus.req1_b = 32'd7; bus.req1_cin = 0; bus.req1_op = 3'b001;
        for (int phase = 1; phase <= 2; phase++) begin
            // walk to EXEC (phase 1) or RESP (phase 2), then reset
            for (int k = 0; k < phase; k++) tick();
            if (phase == 2) begin
                total_cnt++;
                if (bus.resp0_valid !== 1'b1) $display("FAIL rst_mid_pre_resp got %b want 1", bus.resp0_valid);
                else pass_cnt++;
            end
            reset = 1;
            tick();
            total_cnt++;
            if ({bus.busy, bus.resp0_valid, bus.resp1_valid, bus.resp_result} !== {3'b000, 33'h0})
                $display("FAIL rst_mid_%0d got busy=%b v0=%b v1=%b result=%h want 0 0 0 0", phase,
                         bus.busy, bus.resp0_valid, bus.resp1_valid, bus.resp_result);
            else pass_cnt++;
            reset = 0;
            #1;
            total_cnt++;
            if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
                $display("FAIL rst_mid_tie_%0d got %b want 10", phase, {bus.req0_ready, bus.req1_ready});
            else pass_cnt++;
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_random;
        logic        pend0 = 0, pend1 = 0, m_last = 1, m_owner = 0, g1;
        logic        e0, e1, granted, consumed;
        logic [32:0] exp_res = '0;
        int          phase = 0, done = 0, next_phase;
        reset = 1; idle_inputs();
        tick();
        reset = 0;
        for (int cyc = 0; cyc < 30000 && done < 1000; cyc++) begin
            if (!pend0 && $urandom_range(0, 3) != 0) begin
                pend0 = 1; bus.req0_a = $urandom; bus.req0_b = $urandom;
                bus.req0_cin = 1'($urandom_range(0, 1)); bus.req0_op = 3'($urandom_range(0, 7));
            end
            if (!pend1 && $urandom_range(0, 3) != 0) begin
                pend1 = 1; bus.req1_a = $urandom; bus.req1_b = $urandom;
                bus.req1_cin = 1'($urandom_range(0, 1)); bus.req1_op = 3'($urandom_range(0, 7));
            end
            bus.req0_valid = pend0; bus.req1_valid = pend1;
            bus.resp0_ready = 1'($urandom_range(0, 1));
            bus.resp1_ready = 1'($urandom_range(0, 1));
            #1;
            g1 = pend1 & (~pend0 | ~m_last);
            e1 = (phase == 0) & g1;
            e0 = (phase == 0) & pend0 & ~g1;
            total_cnt++;
            if ({bus.req0_ready, bus.req1_ready} !== {e0, e1})
                $display("FAIL rnd_grant cycle %0d got %b want %b", cyc, {bus.req0_ready, bus.req1_ready}, {e0, e1});
            else pass_cnt++;
            total_cnt++;
            if ({bus.resp0_valid, bus.resp1_valid} !== {phase == 2 && !m_owner, phase == 2 && m_owner})
                $display("FAIL rnd_resp_valid cycle %0d got %b want %b", cyc, {bus.resp0_valid, bus.resp1_valid},
                         {phase == 2 && !m_owner, phase == 2 && m_owner});
            else pass_cnt++;
            next_phase = phase;
            consumed = (phase == 2) && (m_owner ? bus.resp1_ready : bus.resp0_ready);
            granted = e0 | e1;
            if (phase == 1) next_phase = 2;
            if (consumed) begin
                total_cnt++;
                if (bus.resp_result !== exp_res)
                    $display("FAIL rnd_result txn %0d owner %0d got %h want %h", done, m_owner, bus.resp_result, exp_res);
                else pass_cnt++;
                done++;
                next_phase = 0;
            end
            if (granted) begin
                m_owner = e1; m_last = e1;
                exp_res = e1 ? alu_model(bus.req1_a, bus.req1_b, bus.req1_cin, bus.req1_op)
                             : alu_model(bus.req0_a, bus.req0_b, bus.req0_cin, bus.req0_op);
                if (e1) pend1 = 0; else pend0 = 0;
                next_phase = 1;
            end
            tick();
            phase = next_phase;
        end
        total_cnt++;
        if (done !== 1000) $display("FAIL rnd_completed got %0d want 1000", done); else pass_cnt++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic_sub();
        test_borrow();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
